// File: rtl/fifo_arbiter.sv
// Round-robin mover from four input FIFOs to four output FIFOs, plus threshold/error supervisor FSM.
// Read-to-write latency 2 cycles; any out_full bit blocks new grants while in-flight words still complete.
module fifo_arbiter #(
  parameter int unsigned          DATA_BITS    = 10,
  parameter int unsigned          ADDR_BITS    = 3,
  parameter logic [ADDR_BITS-1:0] HIGH_DEFAULT = ADDR_BITS'(6),
  parameter logic [ADDR_BITS-1:0] LOW_DEFAULT  = ADDR_BITS'(1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
  input  logic [ADDR_BITS-1:0]   high_limit_in,
  input  logic [ADDR_BITS-1:0]   low_limit_in,
  output logic [ADDR_BITS-1:0]   high_limit,
  output logic [ADDR_BITS-1:0]   low_limit,
  input  logic [3:0]             in_empty,
  input  logic [4*DATA_BITS-1:0] in_data,
  output logic [3:0]             in_read,
  input  logic [3:0]             out_full,
  output logic [3:0]             out_write,
  output logic [DATA_BITS-1:0]   out_data,
  input  logic [7:0]             fifo_error,
  output logic [2:0]             state,
  output logic                   idle_out,
  output logic                   error_out
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t               state_q;
  state_t               state_nx;
  logic [1:0]           ptr_q;
  logic                 s1_vld;
  logic [1:0]           s1_idx;
  logic                 gnt_vld;
  logic [1:0]           gnt_idx;
  logic [1:0]           cand;
  logic [DATA_BITS-1:0] s1_dat;
  logic [1:0]           s1_dest;

  assign state     = state_q;
  assign idle_out  = (state_q == ST_IDLE);
  assign error_out = (state_q == ST_ERROR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RESET;
      high_limit <= HIGH_DEFAULT;
      low_limit  <= LOW_DEFAULT;
    end else begin
      state_q <= state_nx;
      if (state_q == ST_INIT) begin
        high_limit <= high_limit_in;
        low_limit  <= low_limit_in;
      end
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_RESET:  state_nx = ST_INIT;
      ST_INIT:   if (!init) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (init)                  state_nx = ST_INIT;
        else if (in_empty != 4'hF) state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)
          state_nx = ST_INIT;
        else if (in_empty == 4'hF && !s1_vld && out_write == 4'b0000)
          state_nx = ST_IDLE;
      end
      ST_ERROR:  state_nx = ST_ERROR;
      default:   state_nx = ST_RESET;
    endcase
    if (fifo_error != 8'h00) state_nx = ST_ERROR;
  end

  // Search starts one past the last grant; the FIFO read last cycle is skipped
  // because its registered empty flag has not caught up with that read yet.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    if (state_q == ST_ACTIVE && out_full == 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        cand = ptr_q + 2'(k);
        if (!gnt_vld && !in_empty[cand] && !(s1_vld && s1_idx == cand)) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    in_read = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
  end

  // Stage 1 holds the index read last cycle; that FIFO's word is on in_data now.
  assign s1_dat  = in_data[s1_idx*DATA_BITS +: DATA_BITS];
  assign s1_dest = s1_dat[DATA_BITS-1 -: 2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= 2'd3;
      s1_vld    <= 1'b0;
      s1_idx    <= 2'd0;
      out_write <= 4'b0000;
      out_data  <= '0;
    end else if (state_nx == ST_ERROR) begin
      s1_vld    <= 1'b0;
      out_write <= 4'b0000;
    end else begin
      s1_vld <= gnt_vld;
      s1_idx <= gnt_idx;
      if (gnt_vld) ptr_q <= gnt_idx;
      out_write <= s1_vld ? (4'b0001 << s1_dest) : 4'b0000;
      if (s1_vld) out_data <= s1_dat;
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: queue-based input FIFO models, directed scenarios and a randomized
// stream scored against round-robin rules and a read-to-write expectation queue.
module tb_fifo_arbiter;
  localparam int DB = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic [2:0]    high_limit_in = 3'd5;
  logic [2:0]    low_limit_in = 3'd2;
  logic [2:0]    high_limit, low_limit;
  logic [3:0]    in_empty = 4'hF;
  logic [4*DB-1:0] in_data;
  logic [3:0]    in_read;
  logic [3:0]    out_full = 4'h0;
  logic [3:0]    out_write;
  logic [DB-1:0] out_data;
  logic [7:0]    fifo_error = 8'h00;
  logic [2:0]    state;
  logic          idle_out, error_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [DB-1:0] in_q [4][$];
  logic [DB-1:0] dout [4] = '{default: '0};
  logic [DB-1:0] popw;
  int            exp_due[$];
  logic [DB-1:0] exp_word[$];

  assign in_data = {dout[3], dout[2], dout[1], dout[0]};

  fifo_arbiter dut (
    .clk(clk), .reset(reset), .init(init),
    .high_limit_in(high_limit_in), .low_limit_in(low_limit_in),
    .high_limit(high_limit), .low_limit(low_limit),
    .in_empty(in_empty), .in_data(in_data), .in_read(in_read),
    .out_full(out_full), .out_write(out_write), .out_data(out_data),
    .fifo_error(fifo_error), .state(state), .idle_out(idle_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  // Input FIFO models: registered data out and registered empty flag.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (in_read[i] === 1'b1 && in_q[i].size() > 0) begin
        popw = in_q[i].pop_front();
        dout[i] <= popw;
        exp_due.push_back(cyc + 2);
        exp_word.push_back(popw);
      end
      in_empty[i] <= (in_q[i].size() == 0);
    end
    cyc = cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic bring_up();
    @(negedge clk);
    reset = 1'b0; init = 1'b0; out_full = 4'h0; fifo_error = 8'h00;
    for (int i = 0; i < 4; i++) in_q[i].delete();
    exp_due.delete();
    exp_word.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", state); end
    tests++; if (high_limit !== 3'd6 || low_limit !== 3'd1) begin fails++;
      $display("FAIL reset_limits got=%0d/%0d exp=6/1", high_limit, low_limit); end
    tests++; if (in_read !== 4'b0 || out_write !== 4'b0 || out_data !== 10'h0) begin fails++;
      $display("FAIL reset_strobes rd=%b wr=%b dat=%h exp 0", in_read, out_write, out_data); end
    tests++; if (idle_out !== 1'b0 || error_out !== 1'b0) begin fails++;
      $display("FAIL reset_flags idle=%b err=%b exp 0/0", idle_out, error_out); end
    init = 1'b1; high_limit_in = 3'd5; low_limit_in = 3'd2; reset = 1'b1;
    @(negedge clk); #1;
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL init_enter state=%0d exp=1", state); end
    @(negedge clk); #1;
    tests++; if (state !== 3'd1 || high_limit !== 3'd5 || low_limit !== 3'd2) begin fails++;
      $display("FAIL init_load state=%0d limits=%0d/%0d exp 1 5/2", state, high_limit, low_limit); end
    init = 1'b0;
    @(negedge clk); #1;
    tests++; if (state !== 3'd2 || idle_out !== 1'b1) begin fails++;
      $display("FAIL init_exit state=%0d idle=%b exp 2/1", state, idle_out); end
  endtask

  task automatic test_single_word();
    bit found;
    @(negedge clk);
    in_q[2].push_back(10'h2A5);
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk); #1;
      if (in_read !== 4'b0000) found = 1;
    end
    tests++; if (in_read !== 4'b0100 || state !== 3'd3) begin fails++;
      $display("FAIL sw_read rd=%b state=%0d exp 0100/3", in_read, state); end
    @(negedge clk); #1;
    tests++; if (out_write !== 4'b0000 || in_read !== 4'b0000) begin fails++;
      $display("FAIL sw_n1 wr=%b rd=%b exp 0000/0000", out_write, in_read); end
    @(negedge clk); #1;
    tests++; if (out_write !== 4'b0100 || out_data !== 10'h2A5) begin fails++;
      $display("FAIL sw_write wr=%b dat=%h exp 0100/2a5", out_write, out_data); end
    @(negedge clk); #1;
    tests++; if (out_write !== 4'b0000 || out_data !== 10'h2A5) begin fails++;
      $display("FAIL sw_hold wr=%b dat=%h exp 0000/2a5", out_write, out_data); end
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      if (state === 3'd2) found = 1;
      else begin @(negedge clk); #1; end
    end
    tests++; if (!found) begin fails++; $display("FAIL sw_idle state=%0d exp=2", state); end
  endtask

  task automatic test_round_robin();
    logic [DB-1:0] w [4][2];
    int k [4];
    int gs [10];
    int g;
    bit found;
    logic [DB-1:0] we;
    bring_up();
    for (int i = 0; i < 4; i++) begin
      k[i] = 0;
      for (int j = 0; j < 2; j++) begin
        w[i][j] = 10'($urandom_range(0, 1023));
        in_q[i].push_back(w[i][j]);
      end
    end
    for (int c = 0; c < 10; c++) gs[c] = (c < 8) ? c % 4 : -1;
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk); #1;
      if (in_read !== 4'b0000) found = 1;
    end
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      tests++;
      if (in_read !== ((gs[c] >= 0) ? 4'(1 << gs[c]) : 4'b0000)) begin fails++;
        $display("FAIL rr_grant c=%0d rd=%b exp_idx=%0d", c, in_read, gs[c]); end
      if (c >= 2 && gs[c-2] >= 0) begin
        g = gs[c-2]; we = w[g][k[g]]; k[g]++;
        tests++; if (out_write !== 4'(1 << we[DB-1 -: 2]) || out_data !== we) begin fails++;
          $display("FAIL rr_write c=%0d wr=%b dat=%h exp dest=%0d dat=%h", c, out_write, out_data, we[DB-1 -: 2], we); end
      end else begin
        tests++; if (out_write !== 4'b0000) begin fails++;
          $display("FAIL rr_nowrite c=%0d wr=%b exp 0000", c, out_write); end
      end
    end
  endtask

  task automatic test_single_source();
    logic [DB-1:0] w [3];
    int n;
    bit found;
    bring_up();
    for (int j = 0; j < 3; j++) begin
      w[j] = 10'($urandom_range(0, 1023));
      in_q[1].push_back(w[j]);
    end
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk); #1;
      if (in_read !== 4'b0000) found = 1;
    end
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      tests++;
      if (in_read !== ((c == 0 || c == 2 || c == 4) ? 4'b0010 : 4'b0000)) begin fails++;
        $display("FAIL ss_read c=%0d rd=%b", c, in_read); end
      if (c == 2 || c == 4 || c == 6) begin
        tests++; if (out_write !== 4'(1 << w[n][DB-1 -: 2]) || out_data !== w[n]) begin fails++;
          $display("FAIL ss_write c=%0d wr=%b dat=%h exp %h", c, out_write, out_data, w[n]); end
        n++;
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [DB-1:0] w [4][3];
    int k [4];
    int gs [18];
    int g;
    bit found;
    logic [DB-1:0] we;
    bring_up();
    for (int i = 0; i < 4; i++) begin
      k[i] = 0;
      for (int j = 0; j < 3; j++) begin
        w[i][j] = 10'($urandom_range(0, 1023));
        in_q[i].push_back(w[i][j]);
      end
    end
    for (int c = 0; c < 18; c++) begin
      if (c <= 2)       gs[c] = c;
      else if (c <= 6)  gs[c] = -1;
      else if (c <= 15) gs[c] = (c - 4) % 4;
      else              gs[c] = -1;
    end
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk); #1;
      if (in_read !== 4'b0000) found = 1;
    end
    for (int c = 0; c < 18; c++) begin
      if (c > 0) begin
        @(negedge clk);
        out_full = (c >= 3 && c <= 6) ? 4'b1000 : 4'b0000;
        #1;
      end
      tests++;
      if (in_read !== ((gs[c] >= 0) ? 4'(1 << gs[c]) : 4'b0000)) begin fails++;
        $display("FAIL bp_grant c=%0d rd=%b exp_idx=%0d", c, in_read, gs[c]); end
      if (c >= 2 && gs[c-2] >= 0) begin
        g = gs[c-2]; we = w[g][k[g]]; k[g]++;
        tests++; if (out_write !== 4'(1 << we[DB-1 -: 2]) || out_data !== we) begin fails++;
          $display("FAIL bp_write c=%0d wr=%b dat=%h exp %h", c, out_write, out_data, we); end
      end else begin
        tests++; if (out_write !== 4'b0000) begin fails++;
          $display("FAIL bp_nowrite c=%0d wr=%b exp 0000", c, out_write); end
      end
    end
  endtask

  task automatic test_random();
    int last_g, prev_idx, pushed, written, g, idx, j, left;
    bit prev_vld;
    logic [3:0] exp_rd;
    logic [DB-1:0] w;
    bring_up();
    last_g = 3; prev_vld = 0; prev_idx = 0; pushed = 0; written = 0;
    for (int c = 0; c < 460; c++) begin
      @(negedge clk);
      if (c < 400) begin
        idx = $urandom_range(0, 3);
        if ($urandom_range(0, 2) != 0 && in_q[idx].size() < 6) begin
          in_q[idx].push_back(10'($urandom_range(0, 1023)));
          pushed++;
        end
        out_full = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      end else begin
        out_full = 4'b0000;
      end
      #1;
      if (in_read !== 4'b0000) begin
        g = -1;
        if (out_full == 4'b0000) begin
          for (int t = 1; t <= 4; t++) begin
            j = (last_g + t) % 4;
            if (g < 0 && !in_empty[j] && !(prev_vld && prev_idx == j)) g = j;
          end
        end
        exp_rd = (g >= 0) ? 4'(1 << g) : 4'b0000;
        tests++; if (in_read !== exp_rd) begin fails++;
          $display("FAIL rnd_grant c=%0d rd=%b exp=%b full=%b empty=%b", c, in_read, exp_rd, out_full, in_empty); end
        if (g >= 0) last_g = g;
        prev_vld = 1; prev_idx = g;
      end else begin
        prev_vld = 0;
      end
      if (exp_due.size() > 0 && exp_due[0] == cyc) begin
        w = exp_word.pop_front();
        void'(exp_due.pop_front());
        written++;
        tests++; if (out_write !== 4'(1 << w[DB-1 -: 2]) || out_data !== w) begin fails++;
          $display("FAIL rnd_write c=%0d wr=%b dat=%h exp %h", c, out_write, out_data, w); end
      end else begin
        tests++; if (out_write !== 4'b0000) begin fails++;
          $display("FAIL rnd_spurious c=%0d wr=%b", c, out_write); end
      end
    end
    left = 0;
    for (int i = 0; i < 4; i++) left += in_q[i].size();
    tests++; if (written != pushed || left != 0) begin fails++;
      $display("FAIL rnd_drain written=%0d pushed=%0d left=%0d", written, pushed, left); end
    tests++; if (state !== 3'd2) begin fails++; $display("FAIL rnd_idle state=%0d exp=2", state); end
  endtask

  task automatic test_error();
    bit found;
    bring_up();
    for (int j = 0; j < 2; j++) begin
      in_q[0].push_back(10'($urandom_range(0, 1023)));
      in_q[1].push_back(10'($urandom_range(0, 1023)));
    end
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk); #1;
      if (in_read !== 4'b0000) found = 1;
    end
    @(negedge clk); #1;
    tests++; if (state !== 3'd3) begin fails++; $display("FAIL err_active state=%0d exp=3", state); end
    fifo_error = 8'h20;
    @(negedge clk); #1;
    tests++; if (state !== 3'd4 || error_out !== 1'b1 || idle_out !== 1'b0) begin fails++;
      $display("FAIL err_enter state=%0d err=%b idle=%b exp 4/1/0", state, error_out, idle_out); end
    fifo_error = 8'h00; init = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tests++; if (state !== 3'd4 || in_read !== 4'b0000 || out_write !== 4'b0000) begin fails++;
        $display("FAIL err_sticky c=%0d state=%0d rd=%b wr=%b exp 4/0000/0000", c, state, in_read, out_write); end
      @(negedge clk); #1;
    end
    init = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_single_source();
    test_back_pressure();
    test_random();
    test_error();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Round-robin arbiter and configuration controller for a bank of four input FIFOs feeding four output FIFOs, all instances of the team's 10-bit × 8-entry `fifo`. It pops words from non-empty input FIFOs in round-robin order and routes each word to the output FIFO named by its two destination bits. It stalls on downstream full flags. It also distributes the `high_limit`/`low_limit` thresholds to all eight FIFOs and supervises their error flags through a five-state FSM.

## Interface
- `DATA_BITS`, 10, FIFO word width; bits `[DATA_BITS-1:DATA_BITS-2]` are the destination index.
- `ADDR_BITS`, 3, FIFO address width; it is also the threshold width.
- `HIGH_DEFAULT`, 3'd6, high threshold value loaded at reset.
- `LOW_DEFAULT`, 3'd1, low threshold value loaded at reset.

- `clk`  in  1  the single clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `init`  in  1  request to enter INIT and load new thresholds.
- `high_limit_in`  in  ADDR_BITS  requested high threshold.
- `low_limit_in`  in  ADDR_BITS  requested low threshold.
- `high_limit`  out  ADDR_BITS  registered high threshold, driven to all eight FIFOs.
- `low_limit`  out  ADDR_BITS  registered low threshold, driven to all eight FIFOs.
- `in_empty`  in  4  `fifo_empty_out` of input FIFOs 0..3.
- `in_data`  in  4*DATA_BITS  `fifo_data_out` of the input FIFOs; FIFO i occupies slice `[i*DATA_BITS +: DATA_BITS]`.
- `in_read`  out  4  `fifo_read` to the input FIFOs; at most one bit is high.
- `out_full`  in  4  `fifo_full_out` of output FIFOs 0..3.
- `out_write`  out  4  `fifo_write` to the output FIFOs; at most one bit is high.
- `out_data`  out  DATA_BITS  shared `fifo_data_in` bus to the output FIFOs.
- `fifo_error`  in  8  `error_fifo_out`; bits 3:0 are the input FIFOs, bits 7:4 the output FIFOs.
- `state`  out  3  current FSM state.
- `idle_out`  out  1  high when `state` is IDLE.
- `error_out`  out  1  high when `state` is ERROR.

## Operation
- **State encoding:** RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- **Reset values (`reset`=0, asynchronous):**
  - `state`=RESET.
  - `high_limit`=HIGH_DEFAULT, `low_limit`=LOW_DEFAULT.
  - `in_read`=0, `out_write`=0, `out_data`=0.
  - `idle_out`=0, `error_out`=0.
  - Round-robin pointer set so the first grant goes to FIFO 0.
  - Pipeline valid bits cleared.
- **FSM transitions** (the ERROR check has priority over all others):
  - RESET → INIT on the first edge after `reset` goes high.
  - INIT: `high_limit`/`low_limit` are loaded from the `_in` inputs on every edge. Go to IDLE when `init`=0.
  - IDLE → INIT if `init`=1; else → ACTIVE if any `in_empty` bit is 0.
  - ACTIVE → INIT if `init`=1. ACTIVE → IDLE when all `in_empty`=1 and no pipeline stage is valid.
  - Any state → ERROR if any `fifo_error` bit is 1. ERROR is sticky; only `reset` leaves it.
- **Grant rules:** reads are issued only in ACTIVE. A grant is made in a cycle only when all of the following hold:
  - `out_full`==0 (global stall; the destination is unknown until the word is read);
  - the candidate FIFO has `in_empty`=0;
  - the candidate FIFO was not granted in the previous cycle.
- **Round-robin order:** the search starts at pointer+1 mod 4 and the first eligible FIFO wins. The pointer updates to the granted index only.
- **Datapath, 2 stages:**
  - Stage 1 captures the `in_data` slice of the FIFO granted in the previous cycle.
  - Stage 2 registers `out_data` and sets `out_write[dest]`=1 for one cycle.
  - `out_data` holds its last value when `out_write`=0.
- **Leaving ACTIVE for INIT:** no new reads are issued, and words already in the pipeline still complete their writes.
- **Entering ERROR:** the pipeline is flushed; `in_read` and `out_write` are forced to 0 from the ERROR edge onward.
- **Threshold requirement:** the output FIFOs' `high_limit` must leave at least 2 free entries, to absorb the up-to-2 words in flight when `out_full` rises.

## Timing
- A read issued at edge N (`in_read[i]` high in cycle N) has its data valid on `in_data` in cycle N+1. `out_write[dest]` and `out_data` are high/valid in cycle N+2; read-to-write latency is 2 cycles.
- Throughput:
  - 1 word/cycle when two or more input FIFOs are non-empty.
  - 1 word per 2 cycles from a single source, because of the no-consecutive-grant rule; this also prevents underflow from the FIFO's registered empty flag.
- `out_full` is sampled combinationally in the grant cycle. When it rises in cycle N, `in_read` is 0 in cycle N, and up to 2 in-flight writes still occur.
- `init` and `fifo_error` take effect on the next edge. `reset` takes effect immediately.
- `idle_out` and `error_out` are decoded from registered `state`, with no extra latency.

## Test plan
- **Reset and init:** hold `reset`=0 for 3 cycles → `state`=0, limits 6/1, all strobes 0. Release with `init`=1, `high_limit_in`=5, `low_limit_in`=2 → `state`=1, limits 5/2. Drop `init` → `state`=2, `idle_out`=1.
- **Single word:** FIFO 2 holds 10'h2A5 → `in_read`=4'b0100 in cycle N; `out_write`=4'b0100 and `out_data`=10'h2A5 in N+2. `state` goes 2→3, then returns to 2 after the pipeline drains.
- **Round robin:** all four input FIFOs non-empty → grants 0,1,2,3,0 in consecutive cycles. Each output word lands on the FIFO named by its bits 9:8.
- **Single source:** only FIFO 1 is non-empty, holding 3 words → `in_read[1]` pulses in cycles N, N+2, N+4 and never in adjacent cycles. No read occurs after `in_empty[1]`=1.
- **Back-pressure:** assert `out_full[3]`=1 mid-stream → `in_read`=0 from that cycle. The 2 in-flight words are still written. Deassert → grants resume at the pointer+1 index.
- **Error:** `fifo_error[5]`=1 in ACTIVE → `state`=4 and `error_out`=1 on the next edge. `in_read` and `out_write` stay 0, and `init` is ignored until `reset`.
